step_pulse_gen: RTL and testbench
=================================

Name: step_pulse_gen

Overview:
- Sits between the stepper timing engine and the DualHBridge/external driver step/dir pins.
- Converts single-cycle step strobes into step pulses with guaranteed minimum high time, minimum low time and direction setup time.
- Keeps a one-deep pending request, flags overruns, and maintains a signed absolute step position for readback over SPI.

Parameters:
- PULSE_CYCLES, 16, step_out high time in CLK cycles (1 us at 16 MHz); must be >= 1.
- LOW_CYCLES, 16, minimum step_out low time after each pulse, also the direction hold time; must be >= 1.
- DIR_SETUP_CYCLES, 8, cycles dir_out is stable before a step_out rising edge, applied only on a direction change; must be >= 1.
- POS_WIDTH, 64, width of the signed position counter.

Ports:
- CLK  in  1  system clock (16 MHz)
- resetn  in  1  asynchronous active-low reset
- step_req  in  1  single-cycle step strobe from the timing engine
- dir_in  in  1  direction qualifier, sampled with step_req; 1 = positive
- step_out  out  1  conditioned step pulse
- dir_out  out  1  conditioned direction
- busy  out  1  high in any state other than IDLE, or while a request is pending
- position  out  POS_WIDTH  signed step count; +1 per pulse when dir_out=1, -1 when dir_out=0
- overrun  out  1  sticky flag: a step request was dropped
- overrun_count  out  8  dropped requests, saturating at 255
- status_clear  in  1  synchronous clear of overrun and overrun_count

Behaviour:
- Reset (async, resetn=0):
  - step_out=0, dir_out=0, position=0, overrun=0, overrun_count=0.
  - pending empty, state IDLE.
  - step_out falls immediately, even mid-pulse.
- All outputs are registered.
- States:
  - IDLE → DIR_SETUP or PULSE_HIGH.
  - DIR_SETUP (DIR_SETUP_CYCLES cycles) → PULSE_HIGH.
  - PULSE_HIGH (PULSE_CYCLES cycles) → PULSE_LOW.
  - PULSE_LOW (LOW_CYCLES cycles) → IDLE, or dispatch pending.
- Dispatch (request taken from step_req in IDLE, or from pending at the end of PULSE_LOW):
  - If the request dir equals dir_out, go to PULSE_HIGH; step_out is high starting the next cycle (latency 1).
  - Otherwise dir_out takes the new value on the dispatch edge and the block enters DIR_SETUP; step_out rises DIR_SETUP_CYCLES cycles after dir_out changes.
- Position:
  - Updates on the edge that enters PULSE_HIGH, using the dir_out value in effect for that pulse.
  - Two's-complement wrap at the limits (0x7FF..F + 1 → 0x800..0).
- Pending buffer (1 entry, stores dir):
  - step_req while not in IDLE and pending empty: store the request.
  - step_req while pending full: drop it, set overrun, increment overrun_count (saturating).
  - step_req in the same cycle pending is dispatched: the new request refills pending; no overrun.
- dir_out never changes during PULSE_HIGH or PULSE_LOW (hold guarantee).
- status_clear:
  - Clears overrun and overrun_count.
  - If a drop occurs in the same cycle, the drop wins: overrun=1, count=1.
- Cycle counter:
  - Shared down-counter, sized to the largest parameter.
  - Reloaded on every state entry.

Optional Feature:
- Macro: STEP_POS_LOAD_EN.
- With it:
  - Adds ports pos_load (in, 1) and pos_load_value (in, POS_WIDTH).
  - pos_load=1 sets position to pos_load_value on the next edge.
  - When a load coincides with entry to PULSE_HIGH, the load wins and that step's ±1 is discarded.
- Without it: no such ports; position changes only through steps and reset.

Test Plan:
- All tests use PULSE_CYCLES=4, LOW_CYCLES=4, DIR_SETUP_CYCLES=2.
1. After reset, step_req with dir_in=0 at cycle 0 → step_out high cycles 1-4, low from cycle 5; busy deasserts after cycle 8; position=-1; dir_out stays 0.
2. Idle, step_req with dir_in=1 at cycle 0 → dir_out=1 from cycle 1, step_out high cycles 3-6, position=+1.
3. step_req (dir 0) at cycles 0 and 2 → second pulse high cycles 9-12, position=-2, overrun=0.
4. step_req at cycles 0, 2 and 3 → overrun=1, overrun_count=1, exactly two pulses; then status_clear → both cleared.
5. resetn low during cycle 2 of a pulse → step_out=0 immediately, position=0; after release, a new step_req produces a normal pulse.
6. STEP_POS_LOAD_EN: pos_load with value 100 on the edge entering PULSE_HIGH → position=100; next step with dir 1 → 101.

Source files
------------

// File: rtl/step_pulse_gen.sv
// Step/dir conditioner: turns single-cycle step strobes into timed step pulses with dir setup/hold.
// Optional STEP_POS_LOAD_EN adds a synchronous position load port pair.
module step_pulse_gen #(
    parameter int unsigned PULSE_CYCLES     = 16,
    parameter int unsigned LOW_CYCLES       = 16,
    parameter int unsigned DIR_SETUP_CYCLES = 8,
    parameter int unsigned POS_WIDTH        = 64
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        step_req,
    input  logic                        dir_in,
    input  logic                        status_clear,
`ifdef STEP_POS_LOAD_EN
    input  logic                        pos_load,
    input  logic [POS_WIDTH-1:0]        pos_load_value,
`endif
    output logic                        step_out,
    output logic                        dir_out,
    output logic                        busy,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        overrun,
    output logic [7:0]                  overrun_count
);

    localparam int unsigned MAX_PL = (PULSE_CYCLES > LOW_CYCLES) ? PULSE_CYCLES : LOW_CYCLES;
    localparam int unsigned MAX_P  = (MAX_PL > DIR_SETUP_CYCLES) ? MAX_PL : DIR_SETUP_CYCLES;
    localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_PULSE_HIGH,
        S_PULSE_LOW
    } state_t;

    state_t                      state, state_n;
    logic [CNT_W-1:0]            cnt, cnt_n;
    logic                        pend_v, pend_v_n;
    logic                        pend_dir, pend_dir_n;
    logic                        dir_n, step_n, busy_n, ov_n;
    logic [7:0]                  ov_cnt_n;
    logic signed [POS_WIDTH-1:0] pos_n;
    logic                        cnt_done, dispatch, disp_dir, disp_pend, drop, enter_high;

    // State and registered outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pend_v        <= 1'b0;
            pend_dir      <= 1'b0;
            step_out      <= 1'b0;
            dir_out       <= 1'b0;
            busy          <= 1'b0;
            position      <= '0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pend_v        <= pend_v_n;
            pend_dir      <= pend_dir_n;
            step_out      <= step_n;
            dir_out       <= dir_n;
            busy          <= busy_n;
            position      <= pos_n;
            overrun       <= ov_n;
            overrun_count <= ov_cnt_n;
        end
    end

    // Next-state, counter, pending slot, position and status
    always_comb begin
        state_n    = state;
        cnt_done   = (cnt == '0);
        cnt_n      = cnt_done ? cnt : cnt - CNT_W'(1);
        dir_n      = dir_out;
        dispatch   = 1'b0;
        pend_v_n   = pend_v;
        pend_dir_n = pend_dir;
        drop       = 1'b0;
        ov_n       = overrun;
        ov_cnt_n   = overrun_count;
        pos_n      = position;

        case (state)
            S_IDLE: begin
                if (pend_v || step_req) dispatch = 1'b1;
            end
            S_DIR_SETUP: begin
                if (cnt_done) begin
                    state_n = S_PULSE_HIGH;
                    cnt_n   = CNT_W'(PULSE_CYCLES - 1);
                end
            end
            S_PULSE_HIGH: begin
                if (cnt_done) begin
                    state_n = S_PULSE_LOW;
                    cnt_n   = CNT_W'(LOW_CYCLES - 1);
                end
            end
            S_PULSE_LOW: begin
                if (cnt_done) begin
                    if (pend_v) begin
                        dispatch = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        // A queued request always goes before a fresh strobe
        disp_dir  = pend_v ? pend_dir : dir_in;
        disp_pend = dispatch && pend_v;
        if (dispatch) begin
            if (disp_dir == dir_out) begin
                state_n = S_PULSE_HIGH;
                cnt_n   = CNT_W'(PULSE_CYCLES - 1);
            end else begin
                dir_n   = disp_dir;
                state_n = S_DIR_SETUP;
                cnt_n   = CNT_W'(DIR_SETUP_CYCLES - 1);
            end
        end

        if (step_req && !(dispatch && !pend_v)) begin
            if (!pend_v || disp_pend) begin
                pend_v_n   = 1'b1;
                pend_dir_n = dir_in;
            end else begin
                drop = 1'b1;
            end
        end else if (disp_pend) begin
            pend_v_n = 1'b0;
        end

        if (drop) begin
            ov_n     = 1'b1;
            ov_cnt_n = status_clear ? 8'd1 :
                       (overrun_count == 8'hFF) ? 8'hFF : overrun_count + 8'd1;
        end else if (status_clear) begin
            ov_n     = 1'b0;
            ov_cnt_n = '0;
        end

        enter_high = (state_n == S_PULSE_HIGH) && (state != S_PULSE_HIGH);
        if (enter_high) pos_n = dir_n ? position + POS_ONE : position - POS_ONE;
`ifdef STEP_POS_LOAD_EN
        if (pos_load) pos_n = pos_load_value;
`endif

        step_n = (state_n == S_PULSE_HIGH);
        busy_n = (state_n != S_IDLE) || pend_v_n;
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with a pulse scoreboard checked at each step_out rise.
module tb_step_pulse_gen;

    logic               CLK = 1'b0;
    logic               resetn, step_req, dir_in, status_clear;
    logic               step_out, dir_out, busy, overrun;
    logic signed [63:0] position;
    logic [7:0]         overrun_count;
`ifdef STEP_POS_LOAD_EN
    logic               pos_load;
    logic [63:0]        pos_load_value;
`endif

    typedef struct {
        int          rise;
        logic        dir;
        logic [63:0] pos;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   p0;
    bit   sb_en    = 1'b1;

    step_pulse_gen #(
        .PULSE_CYCLES(4), .LOW_CYCLES(4), .DIR_SETUP_CYCLES(2), .POS_WIDTH(64)
    ) dut (
        .CLK(CLK), .resetn(resetn), .step_req(step_req), .dir_in(dir_in),
        .status_clear(status_clear),
`ifdef STEP_POS_LOAD_EN
        .pos_load(pos_load), .pos_load_value(pos_load_value),
`endif
        .step_out(step_out), .dir_out(dir_out), .busy(busy), .position(position),
        .overrun(overrun), .overrun_count(overrun_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic req_at(input int k, input logic d);
        go_to(p0 + k);
        step_req = 1'b1;
        dir_in   = d;
        tick(1);
        step_req = 1'b0;
    endtask

    task automatic push(input int rise, input logic d, input logic [63:0] pos);
        exp_t e;
        e.rise = rise; e.dir = d; e.pos = pos;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        p0 = cyc;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) tick(1);
        check(tag, 64'(busy), 64'd0);
    endtask

    // Scoreboard pop on each rising edge, plus high/low time checks
    logic prev_so = 1'b0;
    bit   had_fall = 1'b0;
    int   hi_len = 0, lo_len = 0;
    always @(negedge CLK) begin
        if (!resetn) begin
            prev_so = 1'b0; had_fall = 1'b0; hi_len = 0; lo_len = 0;
        end else begin
            if (step_out && !prev_so) begin
                if (had_fall) check("low_time_min", 64'(lo_len >= 4), 64'd1);
                if (sb_en) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rise_cycle", 64'(cyc), 64'(e.rise));
                        check("rise_dir", 64'(dir_out), 64'(e.dir));
                        check("rise_pos", position, e.pos);
                    end
                end
                hi_len = 0;
            end
            if (!step_out && prev_so) begin
                check("high_time", 64'(hi_len), 64'd4);
                had_fall = 1'b1;
                lo_len = 0;
            end
            if (step_out) hi_len++;
            else lo_len++;
            prev_so = step_out;
        end
    end

    initial begin
        resetn = 1'b0; step_req = 1'b0; dir_in = 1'b0; status_clear = 1'b0;
`ifdef STEP_POS_LOAD_EN
        pos_load = 1'b0; pos_load_value = '0;
`endif
        tick(2);
        check("rst_step_out", 64'(step_out), 64'd0);
        check("rst_dir_out", 64'(dir_out), 64'd0);
        check("rst_position", position, 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_ov_count", 64'(overrun_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        do_reset();

        // Same-direction step
        push(p0 + 1, 1'b0, -64'sd1);
        req_at(0, 1'b0);
        go_to(p0 + 4); check("t1_high_c4", 64'(step_out), 64'd1);
        go_to(p0 + 5); check("t1_low_c5", 64'(step_out), 64'd0);
        go_to(p0 + 8); check("t1_busy_c8", 64'(busy), 64'd1);
        go_to(p0 + 9); check("t1_busy_c9", 64'(busy), 64'd0);
        check("t1_position", position, -64'sd1);
        check("t1_dir_out", 64'(dir_out), 64'd0);

        // Direction change with setup
        do_reset();
        push(p0 + 3, 1'b1, 64'sd1);
        req_at(0, 1'b1);
        check("t2_dir_c1", 64'(dir_out), 64'd1);
        check("t2_step_c1", 64'(step_out), 64'd0);
        go_to(p0 + 7); check("t2_low_c7", 64'(step_out), 64'd0);
        wait_idle("t2_idle", 20);
        check("t2_position", position, 64'sd1);

        // One pending request
        do_reset();
        push(p0 + 1, 1'b0, -64'sd1);
        push(p0 + 9, 1'b0, -64'sd2);
        req_at(0, 1'b0);
        req_at(2, 1'b0);
        wait_idle("t3_idle", 30);
        check("t3_position", position, -64'sd2);
        check("t3_overrun", 64'(overrun), 64'd0);

        // Overrun and clear
        do_reset();
        push(p0 + 1, 1'b0, -64'sd1);
        push(p0 + 9, 1'b0, -64'sd2);
        req_at(0, 1'b0);
        req_at(2, 1'b0);
        req_at(3, 1'b0);
        check("t4_overrun", 64'(overrun), 64'd1);
        check("t4_ov_count", 64'(overrun_count), 64'd1);
        wait_idle("t4_idle", 30);
        check("t4_position", position, -64'sd2);
        status_clear = 1'b1; tick(1); status_clear = 1'b0;
        check("t4_clr_overrun", 64'(overrun), 64'd0);
        check("t4_clr_count", 64'(overrun_count), 64'd0);

        // Drop coinciding with status_clear
        do_reset();
        push(p0 + 1, 1'b0, -64'sd1);
        push(p0 + 9, 1'b0, -64'sd2);
        req_at(0, 1'b0);
        req_at(2, 1'b0);
        req_at(3, 1'b0);
        req_at(4, 1'b0);
        check("t4b_count2", 64'(overrun_count), 64'd2);
        go_to(p0 + 5);
        step_req = 1'b1; status_clear = 1'b1;
        tick(1);
        step_req = 1'b0; status_clear = 1'b0;
        check("t4b_overrun", 64'(overrun), 64'd1);
        check("t4b_count", 64'(overrun_count), 64'd1);
        wait_idle("t4b_idle", 30);

        // Reset mid-pulse
        do_reset();
        push(p0 + 1, 1'b0, -64'sd1);
        req_at(0, 1'b0);
        go_to(p0 + 2);
        check("t5_high_c2", 64'(step_out), 64'd1);
        resetn = 1'b0;
        #1;
        check("t5_step_async", 64'(step_out), 64'd0);
        check("t5_pos_async", position, 64'd0);
        tick(1);
        resetn = 1'b1;
        tick(1);
        p0 = cyc;
        push(p0 + 1, 1'b0, -64'sd1);
        req_at(0, 1'b0);
        wait_idle("t5_idle", 20);
        check("t5_position", position, -64'sd1);

        // Overrun count saturation under continuous requests
        do_reset();
        sb_en = 1'b0;
        step_req = 1'b1; dir_in = 1'b0;
        tick(400);
        step_req = 1'b0;
        wait_idle("sat_idle", 40);
        check("sat_count", 64'(overrun_count), 64'd255);
        check("sat_overrun", 64'(overrun), 64'd1);
        sb_en = 1'b1;

`ifdef STEP_POS_LOAD_EN
        // Load wins over the step on the PULSE_HIGH entry edge
        do_reset();
        push(p0 + 1, 1'b0, 64'd100);
        go_to(p0);
        step_req = 1'b1; dir_in = 1'b0; pos_load = 1'b1; pos_load_value = 64'd100;
        tick(1);
        step_req = 1'b0; pos_load = 1'b0;
        check("t6_load", position, 64'd100);
        wait_idle("t6_idle", 20);
        p0 = cyc;
        push(p0 + 3, 1'b1, 64'd101);
        req_at(0, 1'b1);
        wait_idle("t6_idle2", 20);
        check("t6_after", position, 64'd101);
        pos_load = 1'b1; pos_load_value = 64'h7FFF_FFFF_FFFF_FFFF;
        tick(1);
        pos_load = 1'b0;
        p0 = cyc;
        push(p0 + 1, 1'b1, 64'h8000_0000_0000_0000);
        req_at(0, 1'b1);
        wait_idle("t6_idle3", 20);
        check("t6_wrap", position, 64'h8000_0000_0000_0000);
`endif

        tick(2);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
